// File: rtl/mips_multi_pkg.sv
// ============================================================================
//  Module      : mips_multi_pkg
//  Description : Shared encodings for the multicycle MIPS control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_multi_pkg;

    typedef logic [3:0] state_t;

    // Controller states
    localparam logic [3:0] c_ST_FETCH     = 4'd0;
    localparam logic [3:0] c_ST_DECODE    = 4'd1;
    localparam logic [3:0] c_ST_MEM_ADDR  = 4'd2;
    localparam logic [3:0] c_ST_MEM_READ  = 4'd3;
    localparam logic [3:0] c_ST_MEM_WB    = 4'd4;
    localparam logic [3:0] c_ST_MEM_WRITE = 4'd5;
    localparam logic [3:0] c_ST_R_EX      = 4'd6;
    localparam logic [3:0] c_ST_SHIFT_EX  = 4'd7;
    localparam logic [3:0] c_ST_R_WB      = 4'd8;
    localparam logic [3:0] c_ST_I_EX      = 4'd9;
    localparam logic [3:0] c_ST_I_WB      = 4'd10;
    localparam logic [3:0] c_ST_BRANCH    = 4'd11;
    localparam logic [3:0] c_ST_JUMP      = 4'd12;
    localparam logic [3:0] c_ST_JAL       = 4'd13;
    localparam logic [3:0] c_ST_JR        = 4'd14;
    localparam logic [3:0] c_ST_HALT      = 4'd15;

    // Opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] c_FN_SLL = 6'h00;
    localparam logic [5:0] c_FN_SRL = 6'h02;
    localparam logic [5:0] c_FN_JR  = 6'h08;
    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    // ALU operations
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SLL = 3'b011;
    localparam logic [2:0] c_ALU_SRL = 3'b100;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    // Datapath mux selects
    localparam logic [1:0] c_RWA_RT       = 2'd0;
    localparam logic [1:0] c_RWA_RD       = 2'd1;
    localparam logic [1:0] c_RWA_RA       = 2'd2;
    localparam logic [1:0] c_RWD_ALU      = 2'd0;
    localparam logic [1:0] c_RWD_MDR      = 2'd1;
    localparam logic [1:0] c_RWD_PC       = 2'd2;
    localparam logic       c_IOD_PC       = 1'b0;
    localparam logic       c_IOD_ALU      = 1'b1;
    localparam logic [1:0] c_SRCA_PC      = 2'd0;
    localparam logic [1:0] c_SRCA_A       = 2'd1;
    localparam logic [1:0] c_SRCA_B       = 2'd2;
    localparam logic [2:0] c_SRCB_B       = 3'd0;
    localparam logic [2:0] c_SRCB_FOUR    = 3'd1;
    localparam logic [2:0] c_SRCB_SIMM    = 3'd2;
    localparam logic [2:0] c_SRCB_SIMM_SH = 3'd3;
    localparam logic [2:0] c_SRCB_SHAMT   = 3'd4;
    localparam logic [1:0] c_PCSRC_ALU    = 2'd0;
    localparam logic [1:0] c_PCSRC_ALUREG = 2'd1;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] c_PCSRC_A      = 2'd3;

endpackage

`default_nettype wire

// File: rtl/multi_controller_alu_decoder.sv
// ============================================================================
//  Module      : alu_decoder
//  Description : R-type funct to ALU operation, with a funct-legal flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
    import mips_multi_pkg::*;
(
    input  logic [5:0] i_func,
    output logic [2:0] o_alu_ctrl,
    output logic       o_legal
);

    always_comb begin
        o_alu_ctrl = c_ALU_AND;
        o_legal    = 1'b1;
        case (i_func)
            c_FN_ADD: o_alu_ctrl = c_ALU_ADD;
            c_FN_SUB: o_alu_ctrl = c_ALU_SUB;
            c_FN_AND: o_alu_ctrl = c_ALU_AND;
            c_FN_OR:  o_alu_ctrl = c_ALU_OR;
            c_FN_SLT: o_alu_ctrl = c_ALU_SLT;
            c_FN_SLL: o_alu_ctrl = c_ALU_SLL;
            c_FN_SRL: o_alu_ctrl = c_ALU_SRL;
            c_FN_JR:  o_alu_ctrl = c_ALU_AND;
            default:  o_legal    = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multi_controller.sv
// ============================================================================
//  Module      : multi_controller
//  Description : Moore control FSM for the multicycle MIPS datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_controller
    import mips_multi_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] operation,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       reg_we,
    output logic [1:0] reg_write_addr,
    output logic [1:0] reg_write_data,
    output logic       instr_reg_we,
    output logic       instr_or_data,
    output logic       pc_reg_we,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_controller,
    output logic       mem_we,
    output logic       illegal,
    output logic [3:0] state_o
);

    localparam logic [3:0] c_ST_ILLEGAL = TRAP_ON_ILLEGAL ? c_ST_HALT : c_ST_FETCH;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [2:0] w_funct_alu;
    logic       w_funct_legal;
    logic       w_reg_we;
    logic       w_ir_we;
    logic       w_pc_we;
    logic       w_mem_we;

    alu_decoder u_alu_decoder (
        .i_func     (func),
        .o_alu_ctrl (w_funct_alu),
        .o_legal    (w_funct_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_FETCH:     if (mem_ready) w_next = c_ST_DECODE;
            c_ST_DECODE: begin
                case (operation)
                    c_OP_RTYPE: begin
                        if (!w_funct_legal)                          w_next = c_ST_ILLEGAL;
                        else if (func == c_FN_JR)                    w_next = c_ST_JR;
                        else if (func == c_FN_SLL || func == c_FN_SRL) w_next = c_ST_SHIFT_EX;
                        else                                         w_next = c_ST_R_EX;
                    end
                    c_OP_LW, c_OP_SW:     w_next = c_ST_MEM_ADDR;
                    c_OP_ADDI, c_OP_SLTI: w_next = c_ST_I_EX;
                    c_OP_BEQ, c_OP_BNE:   w_next = c_ST_BRANCH;
                    c_OP_J:               w_next = c_ST_JUMP;
                    c_OP_JAL:             w_next = c_ST_JAL;
                    default:              w_next = c_ST_ILLEGAL;
                endcase
            end
            c_ST_MEM_ADDR:  w_next = (operation == c_OP_SW) ? c_ST_MEM_WRITE : c_ST_MEM_READ;
            c_ST_MEM_READ:  if (mem_ready) w_next = c_ST_MEM_WB;
            c_ST_MEM_WRITE: if (mem_ready) w_next = c_ST_FETCH;
            c_ST_R_EX,
            c_ST_SHIFT_EX:  w_next = c_ST_R_WB;
            c_ST_I_EX:      w_next = c_ST_I_WB;
            c_ST_HALT:      w_next = c_ST_HALT;
            default:        w_next = c_ST_FETCH;
        endcase
    end

    always_comb begin
        w_reg_we       = 1'b0;
        w_ir_we        = 1'b0;
        w_pc_we        = 1'b0;
        w_mem_we       = 1'b0;
        reg_write_addr = c_RWA_RT;
        reg_write_data = c_RWD_ALU;
        instr_or_data  = c_IOD_PC;
        alu_src_a      = c_SRCA_PC;
        alu_src_b      = c_SRCB_B;
        pc_src         = c_PCSRC_ALU;
        alu_controller = c_ALU_AND;
        case (r_state)
            c_ST_FETCH: begin
                w_ir_we        = 1'b1;
                w_pc_we        = mem_ready;
                alu_src_b      = c_SRCB_FOUR;
                alu_controller = c_ALU_ADD;
            end
            c_ST_DECODE: begin
                alu_src_b      = c_SRCB_SIMM_SH;
                alu_controller = c_ALU_ADD;
            end
            c_ST_MEM_ADDR: begin
                alu_src_a      = c_SRCA_A;
                alu_src_b      = c_SRCB_SIMM;
                alu_controller = c_ALU_ADD;
            end
            c_ST_MEM_READ:  instr_or_data = c_IOD_ALU;
            c_ST_MEM_WB: begin
                w_reg_we       = 1'b1;
                reg_write_data = c_RWD_MDR;
            end
            c_ST_MEM_WRITE: begin
                instr_or_data = c_IOD_ALU;
                w_mem_we      = 1'b1;
            end
            c_ST_R_EX: begin
                alu_src_a      = c_SRCA_A;
                alu_controller = w_funct_alu;
            end
            c_ST_SHIFT_EX: begin
                alu_src_a      = c_SRCA_B;
                alu_src_b      = c_SRCB_SHAMT;
                alu_controller = w_funct_alu;
            end
            c_ST_R_WB: begin
                w_reg_we       = 1'b1;
                reg_write_addr = c_RWA_RD;
            end
            c_ST_I_EX: begin
                alu_src_a      = c_SRCA_A;
                alu_src_b      = c_SRCB_SIMM;
                alu_controller = (operation == c_OP_SLTI) ? c_ALU_SLT : c_ALU_ADD;
            end
            c_ST_I_WB:      w_reg_we = 1'b1;
            c_ST_BRANCH: begin
                alu_src_a      = c_SRCA_A;
                alu_controller = c_ALU_SUB;
                pc_src         = c_PCSRC_ALUREG;
                w_pc_we        = (operation == c_OP_BNE) ? !zero : zero;
            end
            c_ST_JUMP: begin
                pc_src  = c_PCSRC_JUMP;
                w_pc_we = 1'b1;
            end
            // pc still holds pc+4 here, so it is the link value written to $31
            c_ST_JAL: begin
                pc_src         = c_PCSRC_JUMP;
                w_pc_we        = 1'b1;
                w_reg_we       = 1'b1;
                reg_write_addr = c_RWA_RA;
                reg_write_data = c_RWD_PC;
            end
            c_ST_JR: begin
                pc_src  = c_PCSRC_A;
                w_pc_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign reg_we       = w_reg_we & ~rst;
    assign instr_reg_we = w_ir_we  & ~rst;
    assign pc_reg_we    = w_pc_we  & ~rst;
    assign mem_we       = w_mem_we & ~rst;
    assign illegal      = (r_state == c_ST_HALT);
    assign state_o      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multi_controller.sv
// ============================================================================
//  Module      : tb_multi_controller
//  Description : Directed scoreboard bench for multi_controller (trap and NOP builds).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] operation = 6'h00;
    logic [5:0] func = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic       reg_we, instr_reg_we, instr_or_data, pc_reg_we, mem_we, illegal;
    logic [1:0] reg_write_addr, reg_write_data, alu_src_a, pc_src;
    logic [2:0] alu_src_b, alu_controller;
    logic [3:0] state_o;

    logic       reg_we2, instr_reg_we2, instr_or_data2, pc_reg_we2, mem_we2, illegal2;
    logic [1:0] reg_write_addr2, reg_write_data2, alu_src_a2, pc_src2;
    logic [2:0] alu_src_b2, alu_controller2;
    logic [3:0] state_o2;

    always #5 clk = ~clk;

    multi_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .operation(operation), .func(func), .zero(zero),
        .mem_ready(mem_ready), .reg_we(reg_we), .reg_write_addr(reg_write_addr),
        .reg_write_data(reg_write_data), .instr_reg_we(instr_reg_we),
        .instr_or_data(instr_or_data), .pc_reg_we(pc_reg_we), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_controller(alu_controller),
        .mem_we(mem_we), .illegal(illegal), .state_o(state_o)
    );

    multi_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .rst(rst), .operation(operation), .func(func), .zero(zero),
        .mem_ready(mem_ready), .reg_we(reg_we2), .reg_write_addr(reg_write_addr2),
        .reg_write_data(reg_write_data2), .instr_reg_we(instr_reg_we2),
        .instr_or_data(instr_or_data2), .pc_reg_we(pc_reg_we2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .pc_src(pc_src2), .alu_controller(alu_controller2),
        .mem_we(mem_we2), .illegal(illegal2), .state_o(state_o2)
    );

    // {state, reg_we, rwa, rwd, ir_we, iod, pc_we, src_a, src_b, pc_src, alu, mem_we, illegal}
    wire [23:0] w_act = {state_o, reg_we, reg_write_addr, reg_write_data, instr_reg_we,
                         instr_or_data, pc_reg_we, alu_src_a, alu_src_b, pc_src,
                         alu_controller, mem_we, illegal};
    wire [23:0] w_act2 = {state_o2, reg_we2, reg_write_addr2, reg_write_data2, instr_reg_we2,
                          instr_or_data2, pc_reg_we2, alu_src_a2, alu_src_b2, pc_src2,
                          alu_controller2, mem_we2, illegal2};

    typedef struct {
        string      nm;
        logic [23:0] e;
        logic [23:0] e2;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [23:0] ev(
        input logic [3:0] st, input logic rwe, input logic [1:0] rwa, input logic [1:0] rwd,
        input logic irwe, input logic iod, input logic pcwe, input logic [1:0] sa,
        input logic [2:0] sb, input logic [1:0] ps, input logic [2:0] alu,
        input logic mwe, input logic ill);
        return {st, rwe, rwa, rwd, irwe, iod, pcwe, sa, sb, ps, alu, mwe, ill};
    endfunction

    task automatic step2(input string nm, input logic r, input logic [5:0] op,
                         input logic [5:0] fn, input logic z, input logic rdy,
                         input logic [23:0] e, input logic [23:0] e2);
        exp_t it;
        @(posedge clk);
        #1;
        rst = r; operation = op; func = fn; zero = z; mem_ready = rdy;
        it.nm = nm; it.e = e; it.e2 = e2;
        q.push_back(it);
    endtask

    task automatic step(input string nm, input logic r, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input logic rdy,
                        input logic [23:0] e);
        step2(nm, r, op, fn, z, rdy, e, e);
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t it;
            it = q.pop_front();
            n_checks++;
            if (w_act !== it.e) begin
                n_fail++;
                $display("FAIL %s trap: got %h expected %h", it.nm, w_act, it.e);
            end
            n_checks++;
            if (w_act2 !== it.e2) begin
                n_fail++;
                $display("FAIL %s nop: got %h expected %h", it.nm, w_act2, it.e2);
            end
        end
    end

    initial begin
        logic [23:0] f_rst, f_go, f_stall, dec, ma, mr, mwb, mw, rex_sub, sh_sll;
        logic [23:0] rwb, iex_add, iex_slt, iwb, br_t, br_n, jmp, jal, jr, hlt;
        int waited;

        f_rst   = ev(4'd0,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1, 2'd0, 3'b010, 1'b0, 1'b0);
        f_go    = ev(4'd0,  1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd1, 2'd0, 3'b010, 1'b0, 1'b0);
        f_stall = ev(4'd0,  1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd1, 2'd0, 3'b010, 1'b0, 1'b0);
        dec     = ev(4'd1,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd3, 2'd0, 3'b010, 1'b0, 1'b0);
        ma      = ev(4'd2,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd2, 2'd0, 3'b010, 1'b0, 1'b0);
        mr      = ev(4'd3,  1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 3'b000, 1'b0, 1'b0);
        mwb     = ev(4'd4,  1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 3'b000, 1'b0, 1'b0);
        mw      = ev(4'd5,  1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 3'b000, 1'b1, 1'b0);
        rex_sub = ev(4'd6,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 2'd0, 3'b110, 1'b0, 1'b0);
        sh_sll  = ev(4'd7,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd2, 3'd4, 2'd0, 3'b011, 1'b0, 1'b0);
        rwb     = ev(4'd8,  1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 3'b000, 1'b0, 1'b0);
        iex_add = ev(4'd9,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd2, 2'd0, 3'b010, 1'b0, 1'b0);
        iex_slt = ev(4'd9,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd2, 2'd0, 3'b111, 1'b0, 1'b0);
        iwb     = ev(4'd10, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 3'b000, 1'b0, 1'b0);
        br_t    = ev(4'd11, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 2'd1, 3'b110, 1'b0, 1'b0);
        br_n    = ev(4'd11, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 2'd1, 3'b110, 1'b0, 1'b0);
        jmp     = ev(4'd12, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd2, 3'b000, 1'b0, 1'b0);
        jal     = ev(4'd13, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd2, 3'b000, 1'b0, 1'b0);
        jr      = ev(4'd14, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd3, 3'b000, 1'b0, 1'b0);
        hlt     = ev(4'd15, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 3'b000, 1'b0, 1'b1);

        // Reset held three cycles, then FETCH with live enables
        for (int i = 0; i < 3; i++) step("reset", 1'b1, 6'h00, 6'h00, 1'b0, 1'b1, f_rst);
        step("post_reset_fetch", 1'b0, 6'h23, 6'h00, 1'b0, 1'b1, f_go);

        // lw with two stalled MEM_READ cycles
        step("lw_decode",   1'b0, 6'h23, 6'h00, 1'b0, 1'b1, dec);
        step("lw_addr",     1'b0, 6'h23, 6'h00, 1'b0, 1'b1, ma);
        step("lw_read0",    1'b0, 6'h23, 6'h00, 1'b0, 1'b0, mr);
        step("lw_read1",    1'b0, 6'h23, 6'h00, 1'b0, 1'b0, mr);
        step("lw_read2",    1'b0, 6'h23, 6'h00, 1'b0, 1'b1, mr);
        step("lw_wb",       1'b0, 6'h23, 6'h00, 1'b0, 1'b1, mwb);

        // sw with a stalled FETCH and a stalled MEM_WRITE
        step("sw_fetch_stall", 1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, f_stall);
        step("sw_fetch",       1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, f_go);
        step("sw_decode",      1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, dec);
        step("sw_addr",        1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, ma);
        step("sw_write_stall", 1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, mw);
        step("sw_write",       1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, mw);

        // beq taken, bne not taken, bne taken
        step("beq_fetch",  1'b0, 6'h04, 6'h00, 1'b1, 1'b1, f_go);
        step("beq_decode", 1'b0, 6'h04, 6'h00, 1'b1, 1'b1, dec);
        step("beq_branch", 1'b0, 6'h04, 6'h00, 1'b1, 1'b1, br_t);
        step("bne_fetch",  1'b0, 6'h05, 6'h00, 1'b1, 1'b1, f_go);
        step("bne_decode", 1'b0, 6'h05, 6'h00, 1'b1, 1'b1, dec);
        step("bne_z1",     1'b0, 6'h05, 6'h00, 1'b1, 1'b1, br_n);
        step("bne_fetch2", 1'b0, 6'h05, 6'h00, 1'b0, 1'b1, f_go);
        step("bne_decode2",1'b0, 6'h05, 6'h00, 1'b0, 1'b1, dec);
        step("bne_z0",     1'b0, 6'h05, 6'h00, 1'b0, 1'b1, br_t);

        // Jumps
        step("jal_fetch",  1'b0, 6'h03, 6'h00, 1'b0, 1'b1, f_go);
        step("jal_decode", 1'b0, 6'h03, 6'h00, 1'b0, 1'b1, dec);
        step("jal",        1'b0, 6'h03, 6'h00, 1'b0, 1'b1, jal);
        step("j_fetch",    1'b0, 6'h02, 6'h00, 1'b0, 1'b1, f_go);
        step("j_decode",   1'b0, 6'h02, 6'h00, 1'b0, 1'b1, dec);
        step("j",          1'b0, 6'h02, 6'h00, 1'b0, 1'b1, jmp);
        step("jr_fetch",   1'b0, 6'h00, 6'h08, 1'b0, 1'b1, f_go);
        step("jr_decode",  1'b0, 6'h00, 6'h08, 1'b0, 1'b1, dec);
        step("jr",         1'b0, 6'h00, 6'h08, 1'b0, 1'b1, jr);

        // sll then sub
        step("sll_fetch",  1'b0, 6'h00, 6'h00, 1'b0, 1'b1, f_go);
        step("sll_decode", 1'b0, 6'h00, 6'h00, 1'b0, 1'b1, dec);
        step("sll_ex",     1'b0, 6'h00, 6'h00, 1'b0, 1'b1, sh_sll);
        step("sll_wb",     1'b0, 6'h00, 6'h00, 1'b0, 1'b1, rwb);
        step("sub_fetch",  1'b0, 6'h00, 6'h22, 1'b0, 1'b1, f_go);
        step("sub_decode", 1'b0, 6'h00, 6'h22, 1'b0, 1'b1, dec);
        step("sub_ex",     1'b0, 6'h00, 6'h22, 1'b0, 1'b1, rex_sub);
        step("sub_wb",     1'b0, 6'h00, 6'h22, 1'b0, 1'b1, rwb);

        // addi then slti
        step("addi_fetch",  1'b0, 6'h08, 6'h00, 1'b0, 1'b1, f_go);
        step("addi_decode", 1'b0, 6'h08, 6'h00, 1'b0, 1'b1, dec);
        step("addi_ex",     1'b0, 6'h08, 6'h00, 1'b0, 1'b1, iex_add);
        step("addi_wb",     1'b0, 6'h08, 6'h00, 1'b0, 1'b1, iwb);
        step("slti_fetch",  1'b0, 6'h0A, 6'h00, 1'b0, 1'b1, f_go);
        step("slti_decode", 1'b0, 6'h0A, 6'h00, 1'b0, 1'b1, dec);
        step("slti_ex",     1'b0, 6'h0A, 6'h00, 1'b0, 1'b1, iex_slt);
        step("slti_wb",     1'b0, 6'h0A, 6'h00, 1'b0, 1'b1, iwb);

        // Illegal opcode: trap build halts, NOP build keeps cycling FETCH/DECODE
        step("ill_fetch",  1'b0, 6'h3F, 6'h00, 1'b0, 1'b1, f_go);
        step("ill_decode", 1'b0, 6'h3F, 6'h00, 1'b0, 1'b1, dec);
        for (int i = 0; i < 10; i++)
            step2("halt", 1'b0, 6'h3F, 6'h00, 1'b0, 1'b1, hlt, (i % 2 == 0) ? f_go : dec);
        step2("halt_rst", 1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, hlt, f_rst);
        step("halt_exit", 1'b0, 6'h23, 6'h00, 1'b0, 1'b1, f_go);

        // Reset in the middle of a load discards it
        step("mid_decode", 1'b0, 6'h23, 6'h00, 1'b0, 1'b1, dec);
        step("mid_addr",   1'b1, 6'h23, 6'h00, 1'b0, 1'b1, ma);
        step("mid_refetch",1'b0, 6'h23, 6'h00, 1'b0, 1'b1, f_go);

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multi_controller.md
Name: multi_controller

Overview:
- Control unit for the multicycle MIPS core; sits directly upstream of the datapath.
- Reads `operation`/`func`/`zero` from the datapath and drives every datapath select and write-enable, one Moore state per cycle.
- Also drives memory write-enable.
- Honours a memory ready handshake so fetch and load/store cycles can stretch.

Parameters:
- TRAP_ON_ILLEGAL, 1, 1: an unknown opcode/funct enters HALT until reset; 0: it is treated as a NOP and returns to FETCH.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- operation  in  6  instr[31:26] from instruction register
- func  in  6  instr[5:0]
- zero  in  1  ALU zero flag (combinational, current cycle)
- mem_ready  in  1  memory access completes this cycle
- reg_we  out  1  register file write
- reg_write_addr  out  2  0=rt, 1=rd, 2=$31
- reg_write_data  out  2  0=ALU reg, 1=MDR, 2=pc
- instr_reg_we  out  1  instruction register load
- instr_or_data  out  1  memory address: 0=pc, 1=ALU reg
- pc_reg_we  out  1  pc load
- alu_src_a  out  2  0=pc, 1=A, 2=B
- alu_src_b  out  3  0=B, 1=4, 2=simm, 3=simm<<2, 4=shamt
- pc_src  out  2  0=ALU result, 1=ALU reg, 2=jump target, 3=A
- alu_controller  out  3  000 AND, 001 OR, 010 ADD, 011 SLL, 100 SRL, 110 SUB, 111 SLT
- mem_we  out  1  data memory write
- illegal  out  1  sticky while in HALT
- state_o  out  4  current state, for debug

Behaviour:
- **Reset:** synchronous, active-high; state <= FETCH. All write enables (reg_we, pc_reg_we, instr_reg_we, mem_we) are forced 0 while rst=1. After release, outputs equal the FETCH encodings.
- **Output style:** all outputs are pure functions of state, except:
  - pc_reg_we in BRANCH (uses zero);
  - pc_reg_we/instr_reg_we/mem_we in memory states (use mem_ready).
- Select and ALU outputs not listed for a state are 0.
- **FETCH:**
  - instr_or_data=0, instr_reg_we=1.
  - ALU: a=pc, b=4, ADD; pc_src=0.
  - pc_reg_we=mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- **DECODE:**
  - ALU: a=pc, b=simm<<2, ADD (branch target latched into ALU reg).
  - Dispatch on operation:
    - 0x00 R-type: funct 0x08 -> JR; 0x00/0x02 -> SHIFT_EX; 0x20/22/24/25/2A -> R_EX; otherwise illegal.
    - 0x23 lw, 0x2B sw -> MEM_ADDR.
    - 0x08 addi, 0x0A slti -> I_EX.
    - 0x04 beq, 0x05 bne -> BRANCH.
    - 0x02 -> JUMP.
    - 0x03 -> JAL.
    - Other -> HALT (or FETCH, per TRAP_ON_ILLEGAL).
- **MEM_ADDR:** a=A, b=simm, ADD. Next state: MEM_READ for lw, MEM_WRITE for sw.
- **MEM_READ:** instr_or_data=1. Holds until mem_ready, then MEM_WB (MDR captures on the ready edge).
- **MEM_WB:** reg_we=1, reg_write_addr=0, reg_write_data=1 -> FETCH.
- **MEM_WRITE:** instr_or_data=1, mem_we=1 held until mem_ready -> FETCH.
- **R_EX:** a=A, b=B, alu_controller from funct (add->ADD, sub->SUB, and->AND, or->OR, slt->SLT) -> R_WB.
- **SHIFT_EX:** a=B, b=shamt, SLL for funct 0x00, SRL for 0x02 -> R_WB.
- **R_WB:** reg_we=1, reg_write_addr=1, reg_write_data=0 -> FETCH.
- **I_EX:** a=A, b=simm, ADD (addi) or SLT (slti) -> I_WB.
- **I_WB:** reg_we=1, reg_write_addr=0, reg_write_data=0 -> FETCH.
- **BRANCH:**
  - a=A, b=B, SUB, pc_src=1.
  - pc_reg_we = zero for beq, !zero for bne.
  - -> FETCH.
- **JUMP:** pc_src=2, pc_reg_we=1 -> FETCH.
- **JAL:** pc_src=2, pc_reg_we=1, reg_we=1, reg_write_addr=2, reg_write_data=2 (pc still holds pc+4 on this edge) -> FETCH.
- **JR:** pc_src=3, pc_reg_we=1 -> FETCH.
- **HALT:** all enables 0, illegal=1; absorbing until rst.
- **Latency (cycles incl. FETCH, mem_ready=1):**
  - 3: beq, bne, j, jal, jr
  - 4: R-type, shifts, addi, slti, sw
  - 5: lw
- **Boundaries:**
  - mem_ready low stretches FETCH/MEM_READ/MEM_WRITE indefinitely; no pc or IR side effects while stalled beyond repeated IR loads.
  - rst mid-instruction discards it; next state is FETCH.

Decomposition:
- Package mips_multi_pkg:
  - state enum (4-bit);
  - opcode and funct constants;
  - alu_controller codes;
  - select encodings for every mux output.
- One sub-module, alu_decoder: combinational funct -> alu_controller plus funct-legal flag. Used in R_EX and in DECODE's legality check.

Test Plan:
- Reset held 3 cycles, mem_ready=1 -> all enables 0 during reset. First post-reset cycle: state_o=FETCH, instr_reg_we=1, pc_reg_we=1, alu_src_b=1, alu_controller=010.
- lw (op 0x23) with mem_ready low 2 cycles in MEM_READ -> sequence FETCH, DECODE, MEM_ADDR, MEM_READ x3, MEM_WB. reg_we=1 only in MEM_WB, with reg_write_data=1.
- beq with zero=1, then bne with zero=1 -> pc_reg_we=1, pc_src=1 in the first BRANCH; pc_reg_we=0 in the second. Both return to FETCH.
- jal (op 0x03) -> JAL cycle: reg_write_addr=2, reg_write_data=2, pc_src=2, reg_we=1, pc_reg_we=1.
- R-type sll (func 0x00), then sub (func 0x22) -> SHIFT_EX: alu_src_a=2, alu_src_b=4, alu_controller=011. R_EX: alu_controller=110. R_WB: reg_write_addr=1.
- op 0x3F with TRAP_ON_ILLEGAL=1 -> HALT, illegal=1, no enables for 10 cycles; rst returns to FETCH. With TRAP_ON_ILLEGAL=0 -> DECODE goes straight to FETCH.
